// File: rtl/waterfall_fb_arbiter_if.sv
// Bundle of the pixel-read, line-write and frame-buffer RAM signals around the
// waterfall arbiter; slave is the arbiter side, master is its surroundings.
interface waterfall_fb_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 17
);
  logic              rd_req;
  logic [8:0]        rd_x;
  logic [7:0]        rd_y;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              wr_line_done;
  logic              frame_start;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  rd_req, rd_x, rd_y, wr_valid, wr_data, frame_start, mem_rdata,
    output rd_valid, rd_data, wr_ready, wr_line_done, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output rd_req, rd_x, rd_y, wr_valid, wr_data, frame_start, mem_rdata,
    input  rd_valid, rd_data, wr_ready, wr_line_done, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/waterfall_fb_arbiter.sv
// Frame-buffer RAM arbiter: scan-out reads own the port, waterfall line writes
// drain from a small FIFO in idle slots; a circular row pointer scrolls the image.
module waterfall_fb_arbiter #(
  parameter int H_VISIBLE  = 320,
  parameter int V_VISIBLE  = 240,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   resetn,
  waterfall_fb_arbiter_if.slave bus
);
  localparam int ROW_W = $clog2(V_VISIBLE);
  localparam int COL_W = $clog2(H_VISIBLE);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [ROW_W-1:0]  row;
    logic              last;
  } wr_entry_t;

  function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] r);
    if (H_VISIBLE == 320) return (ADDR_W'(r) << 8) + (ADDR_W'(r) << 6);
    else                  return ADDR_W'(r) * ADDR_W'(H_VISIBLE);
  endfunction

  wr_entry_t         r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [COL_W-1:0]  r_wr_col;
  logic [ROW_W-1:0]  r_wr_row, r_done_row, r_disp_row;
  logic              r_s1_req, r_s1_hit, r_s2_req, r_s2_hit;
  logic              r_rd_valid, r_mem_we, r_line_done;
  logic [DATA_W-1:0] r_rd_data, r_mem_wdata;
  logic [ADDR_W-1:0] r_mem_addr;

  logic              w_in_range, w_rd_hit, w_full, w_push, w_pop, w_wr_last;
  logic [ROW_W-1:0]  w_y, w_phys_row;
  logic [ADDR_W-1:0] w_rd_addr;
  wr_entry_t         w_head, w_entry;

  always_comb begin
    w_in_range = (int'(bus.rd_x) < H_VISIBLE) && (int'(bus.rd_y) < V_VISIBLE);
    w_rd_hit   = bus.rd_req && w_in_range;
    w_y        = ROW_W'(bus.rd_y);
    // Newest line sits at disp_row; older lines are found by stepping back with wrap.
    w_phys_row = (w_y > r_disp_row) ? ROW_W'(r_disp_row + ROW_W'(V_VISIBLE) - w_y)
                                    : ROW_W'(r_disp_row - w_y);
    w_rd_addr  = row_base(w_phys_row) + ADDR_W'(bus.rd_x);
    w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    w_push     = bus.wr_valid && !w_full;
    w_pop      = !w_rd_hit && (r_count != '0);
    w_head     = r_fifo[r_rd_ptr];
    w_wr_last  = (r_wr_col == COL_W'(H_VISIBLE - 1));
    w_entry.addr = row_base(r_wr_row) + ADDR_W'(r_wr_col);
    w_entry.data = bus.wr_data;
    w_entry.row  = r_wr_row;
    w_entry.last = w_wr_last;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_col    <= '0;
      r_wr_row    <= '0;
      r_done_row  <= ROW_W'(V_VISIBLE - 1);
      r_disp_row  <= ROW_W'(V_VISIBLE - 1);
      r_s1_req    <= 1'b0;
      r_s1_hit    <= 1'b0;
      r_s2_req    <= 1'b0;
      r_s2_hit    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_line_done <= 1'b0;
    end else begin
      r_s1_req    <= bus.rd_req;
      r_s1_hit    <= w_rd_hit;
      r_s2_req    <= r_s1_req;
      r_s2_hit    <= r_s1_hit;
      r_rd_valid  <= r_s2_req;
      r_rd_data   <= r_s2_hit ? bus.mem_rdata : '0;
      r_mem_we    <= 1'b0;
      r_line_done <= 1'b0;

      if (w_rd_hit) begin
        r_mem_addr <= w_rd_addr;
      end else if (w_pop) begin
        r_mem_addr  <= w_head.addr;
        r_mem_wdata <= w_head.data;
        r_mem_we    <= 1'b1;
        r_line_done <= w_head.last;
        if (w_head.last) r_done_row <= w_head.row;
      end

      // Old done_row is taken on a coincident commit, so a frame never tears.
      if (bus.frame_start) r_disp_row <= r_done_row;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_wr_last) begin
          r_wr_col <= '0;
          r_wr_row <= (r_wr_row == ROW_W'(V_VISIBLE - 1)) ? '0 : r_wr_row + ROW_W'(1);
        end else begin
          r_wr_col <= r_wr_col + COL_W'(1);
        end
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.wr_ready     = !w_full;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.rd_data      = r_rd_data;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_we       = r_mem_we;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.wr_line_done = r_line_done;
endmodule

// File: tb/tb_waterfall_fb_arbiter.sv
// Scoreboard bench for waterfall_fb_arbiter: directed stimulus queues expected
// read addresses, read results and RAM writes; a negedge monitor retires them.
module tb_waterfall_fb_arbiter;
  localparam int H = 320;
  localparam int V = 240;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  waterfall_fb_arbiter_if #(.DATA_W(8), .ADDR_W(17)) bus ();

  waterfall_fb_arbiter #(
    .H_VISIBLE(H), .V_VISIBLE(V), .DATA_W(8), .ADDR_W(17), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  typedef struct { int due; logic [7:0]  data; } rexp_t;
  typedef struct { int due; logic [16:0] addr; } aexp_t;
  typedef struct { int due; logic [16:0] addr; logic [7:0] data; logic last; } wexp_t;

  rexp_t rq[$];
  aexp_t aq[$];
  wexp_t wq[$];
  rexp_t m_r;
  aexp_t m_a;
  wexp_t m_w;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_col = 0, m_row = 0, m_lc = 0;
  int accepts = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM, registered read; unwritten words hold a fixed pattern.
  logic [7:0] ram [int];
  always @(posedge clk) begin
    bus.mem_rdata <= ram.exists(int'(bus.mem_addr)) ? ram[int'(bus.mem_addr)]
                                                    : (8'(bus.mem_addr) ^ 8'hA5);
    if (bus.mem_we) ram[int'(bus.mem_addr)] = bus.mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (aq.size() > 0 && aq[0].due <= cyc) begin
        m_a = aq.pop_front();
        if (m_a.due == cyc) begin
          chk("rd_mem_addr", 32'(bus.mem_addr), 32'(m_a.addr));
          chk("rd_slot_we", 32'(bus.mem_we), 32'd0);
        end else flag("rd_addr_missed");
      end
      if (bus.rd_valid) begin
        if (rq.size() == 0) flag("rd_valid_unexpected");
        else begin
          m_r = rq.pop_front();
          chk("rd_latency", 32'(cyc), 32'(m_r.due));
          chk("rd_data", 32'(bus.rd_data), 32'(m_r.data));
        end
      end else if (rq.size() > 0 && rq[0].due < cyc) begin
        void'(rq.pop_front());
        flag("rd_valid_missing");
      end
      if (bus.mem_we) begin
        if (wq.size() == 0) flag("mem_we_unexpected");
        else begin
          m_w = wq.pop_front();
          chk("wr_addr", 32'(bus.mem_addr), 32'(m_w.addr));
          chk("wr_data", 32'(bus.mem_wdata), 32'(m_w.data));
          chk("wr_line_done", 32'(bus.wr_line_done), 32'(m_w.last));
          if (m_w.due >= 0) chk("wr_commit_cycle", 32'(cyc), 32'(m_w.due));
        end
      end else if (wq.size() > 0 && wq[0].due >= 0 && wq[0].due < cyc) begin
        void'(wq.pop_front());
        flag("wr_commit_missing");
      end
      if (bus.wr_line_done && !bus.mem_we) flag("wr_line_done_stray");
    end
  end

  task automatic do_read(input int x, input int y, input logic [16:0] ea,
                         input logic [7:0] ed, input bit inr);
    bus.rd_req = 1'b1;
    bus.rd_x   = 9'(x);
    bus.rd_y   = 8'(y);
    rq.push_back('{due: cyc + 3, data: ed});
    if (inr) aq.push_back('{due: cyc + 1, addr: ea});
    step();
    bus.rd_req = 1'b0;
  endtask

  task automatic push_next();
    bit rdy;
    logic [7:0] d;
    rdy = 1'b0;
    d = 8'(m_col) ^ 8'(m_lc);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    for (int n = 0; n < 64; n++) begin
      rdy = bus.wr_ready;
      step();
      if (rdy) break;
    end
    bus.wr_valid = 1'b0;
    if (!rdy) flag("wr_accept_timeout");
    else begin
      wq.push_back('{due: -1, addr: 17'(m_row * H + m_col), data: d, last: (m_col == H - 1)});
      accepts++;
      if (m_col == H - 1) begin
        m_col = 0;
        m_row = (m_row == V - 1) ? 0 : m_row + 1;
        m_lc++;
      end else m_col++;
    end
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (wq.size() == 0 && rq.size() == 0 && aq.size() == 0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    if (!done) flag("drain_timeout");
  endtask

  task automatic frame_pulse();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
  endtask

  task automatic reset_outputs_check();
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_line_done", 32'(bus.wr_line_done), 32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rd_req = 1'b0; bus.rd_x = '0; bus.rd_y = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.frame_start = 1'b0;

    repeat (3) @(negedge clk);
    reset_outputs_check();
    #1 resetn = 1'b1;
    step();

    // Fresh reset: y=0 is row 239, 239*320+5 = 76485, pattern 0xC5^0xA5 = 0x60
    do_read(5, 0, 17'd76485, 8'h60, 1'b1);
    repeat (6) step();
    wait_drain(10);

    // One full line into row 0, then scroll it to the top
    repeat (H) push_next();
    wait_drain(20);
    frame_pulse();
    do_read(10, 0, 17'd10, 8'h0A, 1'b1);
    wait_drain(10);

    // Reads own every slot for 10 cycles; FIFO fills at 4 and drains afterwards
    accepts = 0;
    fork
      begin
        for (int k = 0; k < 10; k++) do_read(k, 0, 17'(k), 8'(k), 1'b1);
        chk("wr_accepts_during_reads", 32'(accepts), 32'd4);
        chk("wr_ready_when_full", 32'(bus.wr_ready), 32'd0);
        for (int i = 0; i < 4; i++) wq[i].due = cyc + 1 + i;
      end
      begin
        repeat (6) push_next();
      end
    join
    wait_drain(30);

    // Finish row 1, rows 2..239, then row 0 again (241st line): row pointer wraps
    repeat ((H - 6) + 238 * H + H) push_next();
    wait_drain(20);
    frame_pulse();
    do_read(7, 0, 17'd7, 8'hF7, 1'b1);
    do_read(3, 1, 17'd76483, 8'hEC, 1'b1);
    wait_drain(10);

    // Out-of-range reads: pending write takes the free slot; rd_data is 0
    fork
      do_read(0, 0, 17'd0, 8'hF0, 1'b1);
      push_next();
    join
    wq[wq.size() - 1].due = cyc + 1;
    do_read(320, 0, 17'd0, 8'h00, 1'b0);
    do_read(0, 240, 17'd0, 8'h00, 1'b0);
    wait_drain(10);
    chk("mem_addr_hold", 32'(bus.mem_addr), 32'd320);

    // Reset with 3 queued writes and 2 reads in flight
    fork
      repeat (5) do_read(1, 0, 17'd1, 8'hF1, 1'b1);
      repeat (3) push_next();
    join
    @(negedge clk);
    #1 resetn = 1'b0;
    rq.delete(); aq.delete(); wq.delete();
    m_col = 0; m_row = 0; m_lc = 0;
    #1 reset_outputs_check();
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;
    chk("wr_ready_after_reset", 32'(bus.wr_ready), 32'd1);
    step();
    // disp_row back to 239; row 239 was written with lc=239: 2^0xEF = 0xED
    do_read(2, 0, 17'd76482, 8'hED, 1'b1);
    repeat (10) step();
    wait_drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
